// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, funct7 values and the ALU code map.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes; the ALU decodes the same values.
  localparam logic [4:0] ALU_NONE  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_ADDI  = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_ORI   = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_XORI  = 5'd6;
  localparam logic [4:0] ALU_AND   = 5'd7;
  localparam logic [4:0] ALU_ANDI  = 5'd8;
  localparam logic [4:0] ALU_SUB   = 5'd9;
  localparam logic [4:0] ALU_SLT   = 5'd10;
  localparam logic [4:0] ALU_SLTI  = 5'd11;
  localparam logic [4:0] ALU_SLTU  = 5'd12;
  localparam logic [4:0] ALU_SLTIU = 5'd13;
  localparam logic [4:0] ALU_SLLI  = 5'd14;
  localparam logic [4:0] ALU_SRLI  = 5'd15;
  localparam logic [4:0] ALU_SRAI  = 5'd16;
  localparam logic [4:0] ALU_SLL   = 5'd17;
  localparam logic [4:0] ALU_SRL   = 5'd18;
  localparam logic [4:0] ALU_SRA   = 5'd19;

endpackage

// File: rtl/riscv_alu_ctrl_lut.sv
// Combinational OP/OP-IMM decode: instruction word to ALU code, immediate,
// operand-B select and illegal flag.
module riscv_alu_ctrl_lut
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_alu_ctrl,
  output logic [31:0] o_imm,
  output logic        o_use_imm,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Decode table; illegal encodings leave code/imm/use_imm at zero.
  always_comb begin
    o_alu_ctrl = ALU_NONE;
    o_imm      = 32'd0;
    o_use_imm  = 1'b0;
    o_illegal  = 1'b0;
    if (w_opcode == OPC_OP) begin
      unique case (w_funct3)
        3'b000: begin
          if (w_funct7 == F7_BASE)     o_alu_ctrl = ALU_ADD;
          else if (w_funct7 == F7_ALT) o_alu_ctrl = ALU_SUB;
          else                         o_illegal  = 1'b1;
        end
        3'b101: begin
          if (w_funct7 == F7_BASE)     o_alu_ctrl = ALU_SRL;
          else if (w_funct7 == F7_ALT) o_alu_ctrl = ALU_SRA;
          else                         o_illegal  = 1'b1;
        end
        default: begin
          if (w_funct7 != F7_BASE) begin
            o_illegal = 1'b1;
          end else begin
            unique case (w_funct3)
              3'b001:  o_alu_ctrl = ALU_SLL;
              3'b010:  o_alu_ctrl = ALU_SLT;
              3'b011:  o_alu_ctrl = ALU_SLTU;
              3'b100:  o_alu_ctrl = ALU_XOR;
              3'b110:  o_alu_ctrl = ALU_OR;
              default: o_alu_ctrl = ALU_AND;
            endcase
          end
        end
      endcase
    end else if (w_opcode == OPC_OP_IMM) begin
      o_use_imm = 1'b1;
      o_imm     = {{20{i_instr[31]}}, i_instr[31:20]};
      unique case (w_funct3)
        3'b000: o_alu_ctrl = ALU_ADDI;
        3'b010: o_alu_ctrl = ALU_SLTI;
        3'b011: o_alu_ctrl = ALU_SLTIU;
        3'b100: o_alu_ctrl = ALU_XORI;
        3'b110: o_alu_ctrl = ALU_ORI;
        3'b111: o_alu_ctrl = ALU_ANDI;
        3'b001: begin
          o_imm = {27'd0, i_instr[24:20]};
          if (w_funct7 == F7_BASE) o_alu_ctrl = ALU_SLLI;
          else                     o_illegal  = 1'b1;
        end
        default: begin
          o_imm = {27'd0, i_instr[24:20]};
          if (w_funct7 == F7_BASE)     o_alu_ctrl = ALU_SRLI;
          else if (w_funct7 == F7_ALT) o_alu_ctrl = ALU_SRAI;
          else                         o_illegal  = 1'b1;
        end
      endcase
    end else begin
      o_illegal = 1'b1;
    end
    // Illegal words carry no operation, immediate or operand select.
    if (o_illegal) begin
      o_alu_ctrl = ALU_NONE;
      o_imm      = 32'd0;
      o_use_imm  = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_alu_decode.sv
// Registered instruction-to-ALU decode stage with valid/ready handshake and a
// transfer counter. Optional macro RISCV_DEC_ILLEGAL_EN emits illegal words
// with out_illegal set; otherwise they are accepted and silently dropped.
module riscv_alu_decode
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu_ctrl,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
`ifdef RISCV_DEC_ILLEGAL_EN
  output logic             out_illegal,
`endif
  output logic [CNT_W-1:0] dec_count
);

  logic [4:0]       w_alu_ctrl;
  logic [31:0]      w_imm;
  logic             w_use_imm;
  logic             w_illegal;
  logic             w_accept;
  logic             w_keep;

  logic             r_valid;
  logic [4:0]       r_alu_ctrl;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [31:0]      r_imm;
  logic             r_use_imm;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  riscv_alu_ctrl_lut u_lut (
    .i_instr    (in_instr),
    .o_alu_ctrl (w_alu_ctrl),
    .o_imm      (w_imm),
    .o_use_imm  (w_use_imm),
    .o_illegal  (w_illegal)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef RISCV_DEC_ILLEGAL_EN
  assign w_keep      = 1'b1;
  assign out_illegal = r_illegal;
`else
  assign w_keep = !w_illegal;
`endif

  // Output register and transfer counter; an accepted word that is dropped
  // still frees the slot, so out_valid follows w_keep on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_alu_ctrl <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= w_keep;
        if (w_keep) begin
          r_alu_ctrl <= w_alu_ctrl;
          r_rs1      <= in_instr[19:15];
          // OP-IMM has no rs2; use_imm is set exactly for legal OP-IMM.
          r_rs2      <= w_use_imm ? 5'd0 : in_instr[24:20];
          r_rd       <= in_instr[11:7];
          r_imm      <= w_imm;
          r_use_imm  <= w_use_imm;
          r_illegal  <= w_illegal;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && out_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_alu_ctrl = r_alu_ctrl;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_imm      = r_imm;
  assign out_use_imm  = r_use_imm;
  assign dec_count    = r_cnt;

endmodule

// File: tb/tb_riscv_alu_decode.sv
// Directed self-checking bench for riscv_alu_decode.
module tb_riscv_alu_decode;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_alu_ctrl;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [31:0]      out_imm;
  logic             out_use_imm;
`ifdef RISCV_DEC_ILLEGAL_EN
  logic             out_illegal;
`endif
  logic [CNT_W-1:0] dec_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  riscv_alu_decode #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_use_imm  (out_use_imm),
`ifdef RISCV_DEC_ILLEGAL_EN
    .out_illegal  (out_illegal),
`endif
    .dec_count    (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic [4:0] code, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic use_imm);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".code"}, 32'(out_alu_ctrl), 32'(code));
    check({tag, ".rs1"}, 32'(out_rs1), 32'(rs1));
    check({tag, ".rs2"}, 32'(out_rs2), 32'(rs2));
    check({tag, ".rd"}, 32'(out_rd), 32'(rd));
    check({tag, ".imm"}, out_imm, imm);
    check({tag, ".use_imm"}, 32'(out_use_imm), 32'(use_imm));
  endtask

  // Present one illegal word with out_ready high and check the build-specific result.
  task automatic illegal_word(input string tag, input logic [31:0] instr, input logic [4:0] rs2);
    in_instr = instr;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef RISCV_DEC_ILLEGAL_EN
    check_fields(tag, 5'd0, instr[19:15], rs2, instr[11:7], 32'd0, 1'b0);
    check({tag, ".illegal"}, 32'(out_illegal), 32'd1);
    step();
    exp_cnt++;
`else
    check({tag, ".dropped"}, 32'(out_valid), 32'd0);
    step();
`endif
    check({tag, ".cnt"}, 32'(dec_count), 32'(exp_cnt));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b1;
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.cnt", 32'(dec_count), 32'd0);
    check("rst.code", 32'(out_alu_ctrl), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // ADD x3,x1,x2
    in_instr = 32'h002081B3;
    in_valid = 1'b1;
    #1;
    check("add.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_fields("add", 5'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    check("add.cnt_pre", 32'(dec_count), 32'd0);
    step();
    exp_cnt++;
    check("add.cnt", 32'(dec_count), 32'(exp_cnt));
    check("add.valid_fall", 32'(out_valid), 32'd0);

    // ADDI x5,x0,-1
    in_instr = 32'hFFF00293;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_fields("addi", 5'd2, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1);
    step();
    exp_cnt++;

    // SRAI x1,x1,3
    in_instr = 32'h4030D093;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_fields("srai", 5'd16, 5'd1, 5'd0, 5'd1, 32'h00000003, 1'b1);
    step();
    exp_cnt++;
    check("srai.cnt", 32'(dec_count), 32'(exp_cnt));

    // SRAI encoding with funct7 0x7F
    illegal_word("srai_bad", 32'hFE30D093, 5'd3);

    // Stall: SUB held while SLTU waits
    out_ready = 1'b0;
    in_instr  = 32'h402081B3;
    in_valid  = 1'b1;
    step();
    in_instr = 32'h0020B1B3;
    for (int i = 0; i < 3; i++) begin
      check_fields("stall_sub", 5'd9, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
      check("stall.in_ready", 32'(in_ready), 32'd0);
      step();
    end
    check("stall.cnt", 32'(dec_count), 32'(exp_cnt));
    out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    exp_cnt++;
    check_fields("sltu", 5'd12, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    check("sltu.cnt_sub", 32'(dec_count), 32'(exp_cnt));
    step();
    exp_cnt++;
    check("sltu.cnt", 32'(dec_count), 32'(exp_cnt));

    // All-zero word
    illegal_word("zero", 32'h00000000, 5'd0);

    // ORI x7,x1,0x7FF then XOR x4,x5,x6 back to back
    in_instr = 32'h7FF0E393;
    in_valid = 1'b1;
    step();
    check_fields("ori", 5'd4, 5'd1, 5'd0, 5'd7, 32'h000007FF, 1'b1);
    in_instr = 32'h0062C233;
    step();
    in_valid = 1'b0;
    exp_cnt++;
    check_fields("xor", 5'd5, 5'd5, 5'd6, 5'd4, 32'd0, 1'b0);
    step();
    exp_cnt++;
    check("xor.cnt", 32'(dec_count), 32'(exp_cnt));

    // Reset mid-stall
    out_ready = 1'b0;
    in_instr  = 32'h002081B3;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_rst.valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst.valid", 32'(out_valid), 32'd0);
    check("mid_rst.cnt", 32'(dec_count), 32'd0);
    check("mid_rst.code", 32'(out_alu_ctrl), 32'd0);
    check("mid_rst.imm", out_imm, 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    step();
    check("post_rst.valid", 32'(out_valid), 32'd0);
    in_instr = 32'h0062C233;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_fields("post_rst_xor", 5'd5, 5'd5, 5'd6, 5'd4, 32'd0, 1'b0);
    step();
    exp_cnt++;
    check("post_rst.cnt", 32'(dec_count), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
